add_sub_pipe: RTL and testbench
===============================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the integer execute path.
- Operand width, lookahead group size and pipeline depth are configurable. Operation is selectable per transaction: ADD, SUB, SLT, SLTU.
- Produces a result plus carry, overflow, zero and negative flags.
- Valid/ready handshake on both sides, so it can sit between operand issue and writeback with backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP*STAGES.
- GROUP, 4, bits per carry-lookahead group; each group exports group propagate/generate to a second-level lookahead.
- STAGES, 2, pipeline depth and latency in cycles, range 1..WIDTH/GROUP; each stage adds one WIDTH/STAGES-bit slice.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  unit accepts a transaction this cycle.
- op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum, difference, or zero-extended compare bit.
- c_out  output  1  raw carry out of the MSB of a + (b^sub) + sub.
- ovf  output  1  signed overflow of the add/sub.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits, out_valid, result, c_out, ovf, zero and neg go to 0. in_ready reads 1 once rst_n is high. A transaction in flight when reset asserts is dropped and never emitted.
- Operation decode:
  - sub = 1 for SUB, SLT and SLTU.
  - The adder computes a + (b XOR {WIDTH{sub}}) + sub.
- Slicing:
  - Slice k (bits k*W/S .. (k+1)*W/S-1) is added in stage k using GROUP-bit CLA groups and a second-level lookahead across the slice's groups.
  - Carry into slice 0 is sub. Carry out of slice k is registered with the transaction and feeds slice k+1 in the next cycle.
  - Unprocessed operand upper slices and already-computed lower sum slices travel forward in the stage registers (skewed pipeline).
  - STAGES=1 gives a single-cycle registered adder.
- Flags, computed in the final stage from the full sum s:
  - c_out = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Result mux:
  - ADD/SUB: result = s.
  - SLT: result = {0..., s[WIDTH-1]^ovf}.
  - SLTU: result = {0..., ~c_out}.
  - zero and neg always reflect the muxed result. For SLT/SLTU, neg = 0.
  - c_out and ovf always reflect the add/sub regardless of op.
- Latency and throughput:
  - A transaction accepted in cycle t (in_valid & in_ready) appears with out_valid=1 in cycle t+STAGES, provided there is no stall.
  - One transaction per cycle sustained.
- Handshake:
  - stall = out_valid & ~out_ready. When stall is 1, every stage register holds and in_ready = 0.
  - When stall is 0, all stages advance and empty stages accept bubbles.
  - in_ready = ~stall. It is combinational from out_ready, with no combinational path from in_valid.
  - While out_valid & ~out_ready, result and all flags are held stable.
  - out_valid drops after a handshake if no valid transaction is behind it.
- Bubbles: a cycle with in_valid=0 inserts an invalid slot. Stage registers for invalid slots may hold any data, but valid bits stay 0.
- Ordering: strict FIFO order, no reordering, no loss under arbitrary out_ready patterns.

Test Plan:
- WIDTH=32, STAGES=2. ADD a=0x7FFFFFFF, b=1 -> after 2 cycles result=0x80000000, ovf=1, c_out=0, neg=1, zero=0.
- SUB a=5, b=5 -> result=0, zero=1, c_out=1, ovf=0. Then SUB a=0, b=1 -> result=0xFFFFFFFF, c_out=0, neg=1.
- SLT a=0xFFFFFFFF (-1), b=1 -> result=1. SLTU on the same operands -> result=0. SLT a=0x80000000, b=0x7FFFFFFF -> result=1 (uses ovf).
- Back-to-back 100 random ops with out_ready toggling pseudo-randomly -> every result matches the reference model, in order. Outputs stay stable during stalls. in_ready=0 exactly when out_valid & ~out_ready.
- Carry chain across slice boundary: ADD a=0x0000FFFF, b=1 with STAGES=2, 4 and 8 -> result=0x00010000, latency equals STAGES in each case.
- Assert rst_n low mid-stream with 2 transactions in flight -> out_valid=0 immediately. Nothing is emitted after release. The first new transaction returns after STAGES cycles.

Source files
------------

// File: rtl/add_sub_pipe_if.sv
// Operand/result bundle for the pipelined add/sub unit, valid/ready on both sides.
// Latency: none; a wiring bundle only.
// Backpressure: out_ready from the consumer, in_ready back to the issuer.
interface add_sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic             neg;

    // Issuer/consumer side: drives operands and out_ready, observes results.
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, c_out, ovf, zero, neg
    );

    // Execution unit side.
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, c_out, ovf, zero, neg
    );
endinterface

// File: rtl/add_sub_pipe.sv
// Skewed-pipeline carry-lookahead ADD/SUB/SLT/SLTU unit with carry, overflow, zero and negative flags.
// Latency: STAGES cycles from in_valid&in_ready to out_valid; one transaction per cycle sustained.
// Backpressure: out_valid&~out_ready freezes every stage and drops in_ready in the same cycle.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_pipe_if.slave io
);
    // Each stage adds one slice of SW bits, built from NG lookahead groups.
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    // Payload carried between stages: upper operand slices not yet added,
    // lower sum slices already produced, and the carry into the next slice.
    typedef struct packed {
        logic [1:0]       op;
        logic             cy;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] s;
    } stage_t;

    // One slice of the adder: GROUP-bit groups export generate/propagate,
    // a second-level lookahead forms the group carries, and each group then
    // resolves its internal bit carries from its own group carry-in.
    function automatic logic [SW:0] cla_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          cin
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] c;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
                gp[j] = gp[j] & p[j*GROUP+i];
            end
        end
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < NG; j++) begin
            c[j*GROUP] = gc[j];
            for (int i = 1; i < GROUP; i++) begin
                c[j*GROUP+i] = g[j*GROUP+i-1] | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    stage_t           pq_dat [STAGES];
    logic             pq_vld [STAGES];
    stage_t           nx_dat [STAGES];
    logic             nx_vld [STAGES];
    stage_t           cur;
    logic             cur_vld;
    logic [SW:0]      sl;
    logic             sub;
    logic             c_msb;
    logic             fin_ovf;
    logic [WIDTH-1:0] fin_res;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;
    logic             stall;

    // Hold everything while the consumer refuses a presented result; in_ready
    // depends only on registered state and out_ready, never on in_valid.
    assign stall       = out_valid_q & ~io.out_ready;
    assign io.in_ready = ~stall;

    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.c_out     = c_out_q;
    assign io.ovf       = ovf_q;
    assign io.zero      = zero_q;
    assign io.neg       = neg_q;

    // Walk the stages: decode at the input, add slice k in stage k, then the
    // final stage forms flags and the result mux from the completed sum.
    always_comb begin
        sub     = (io.op != OP_ADD);
        cur_vld = io.in_valid;
        cur.op  = io.op;
        cur.cy  = sub;
        cur.a   = io.a;
        cur.bx  = io.b ^ {WIDTH{sub}};
        cur.s   = '0;
        sl      = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl                = cla_add(cur.a[k*SW +: SW], cur.bx[k*SW +: SW], cur.cy);
            cur.s[k*SW +: SW] = sl[SW-1:0];
            cur.cy            = sl[SW];
            nx_dat[k]         = cur;
            nx_vld[k]         = cur_vld;
            if (k < STAGES - 1) begin
                cur     = pq_dat[k];
                cur_vld = pq_vld[k];
            end
        end
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        c_msb   = cur.s[WIDTH-1] ^ cur.a[WIDTH-1] ^ cur.bx[WIDTH-1];
        fin_ovf = c_msb ^ cur.cy;
        fin_res = '0;
        case (cur.op)
            OP_ADD, OP_SUB: fin_res    = cur.s;
            OP_SLT:         fin_res[0] = cur.s[WIDTH-1] ^ fin_ovf;
            OP_SLTU:        fin_res[0] = ~cur.cy;
            default:        fin_res    = cur.s;
        endcase
    end

    // Valid bits and the registered result/flags; all frozen during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pq_vld[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                pq_vld[k] <= nx_vld[k];
            end
            out_valid_q <= cur_vld;
            if (cur_vld) begin
                result_q <= fin_res;
                c_out_q  <= cur.cy;
                ovf_q    <= fin_ovf;
                zero_q   <= (fin_res == '0);
                neg_q    <= fin_res[WIDTH-1];
            end
        end
    end

    // Stage payload needs no reset: it is only ever qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                pq_dat[k] <= nx_dat[k];
            end
        end
    end
endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: directed, random and reset traffic plus slice-carry latency.
// Latency: checked against STAGES whenever out_ready is held high.
// Backpressure: out_ready toggled randomly; held outputs and in_ready rule checked each cycle.
module tb_add_sub_pipe;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    add_sub_pipe_if #(.WIDTH(W)) io2 ();
    add_sub_pipe_if #(.WIDTH(W)) io4 ();
    add_sub_pipe_if #(.WIDTH(W)) io8 ();

    add_sub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .io(io2));
    add_sub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(io4));
    add_sub_pipe #(.WIDTH(W), .GROUP(4), .STAGES(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(io8));

    // Main unit stimulus
    logic         iv   = 1'b0;
    logic [1:0]   iop  = 2'b00;
    logic [W-1:0] ia   = '0;
    logic [W-1:0] ib   = '0;
    logic         ordy = 1'b1;
    bit           rand_ready = 1'b0;

    assign io2.in_valid  = iv;
    assign io2.op        = iop;
    assign io2.a         = ia;
    assign io2.b         = ib;
    assign io2.out_ready = ordy;

    // Deeper units share one ADD stimulus for the slice-boundary carry test
    logic         cv = 1'b0;
    logic [W-1:0] ca = '0;

    assign io4.in_valid  = cv;
    assign io4.op        = 2'b00;
    assign io4.a         = ca;
    assign io4.b         = 32'd1;
    assign io4.out_ready = 1'b1;
    assign io8.in_valid  = cv;
    assign io8.op        = 2'b00;
    assign io8.a         = ca;
    assign io8.b         = 32'd1;
    assign io8.out_ready = 1'b1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;    // {c_out, ovf, zero, neg}
        int           icyc;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: whole-word arithmetic on integers, compares done directly.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int ic, input bit lat);
        exp_t         e;
        bit           sb;
        logic [W-1:0] yx;
        logic [W:0]   u;
        logic [W-1:0] s;
        longint       sr;
        logic [W-1:0] r;
        bit           ov;
        sb = (o != 2'b00);
        yx = sb ? ~y : y;
        u  = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, sb};
        s  = u[W-1:0];
        sr = longint'($signed(x)) + longint'($signed(yx)) + (sb ? 64'sd1 : 64'sd0);
        ov = (sr != longint'($signed(s)));
        case (o)
            2'b10:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            2'b11:   r = (x < y) ? 32'd1 : 32'd0;
            default: r = s;
        endcase
        e.res  = r;
        e.fl   = {u[W], ov, (r == '0), r[W-1]};
        e.icyc = ic;
        e.lat  = lat;
        return e;
    endfunction

    // Present one transaction, hold it until accepted, then log the expectation.
    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit lat);
        bit acc  = 1'b0;
        bit done = 1'b0;
        int ic   = 0;
        int n    = 0;
        iv  = 1'b1;
        iop = o;
        ia  = x;
        ib  = y;
        while (!done && n < 200) begin
            @(negedge clk);
            acc = io2.in_ready;
            ic  = cyc;
            @(posedge clk);
            #1;
            n++;
            if (acc) done = 1'b1;
        end
        iv = 1'b0;
        if (done) exp_q.push_back(model(o, x, y, ic, lat));
        else chk("send_accept", 64'(done), 64'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Consumer readiness: random during the stress phase, otherwise always ready
    always @(posedge clk) begin
        #1;
        ordy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: in_ready rule, hold-under-stall, and in-order scoreboard pops
    bit          prev_stall = 1'b0;
    logic [36:0] prev_out   = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(io2.in_ready), 64'(!(io2.out_valid && !io2.out_ready)));
            if (prev_stall)
                chk("stall_hold", 64'({io2.out_valid, io2.result, io2.c_out, io2.ovf, io2.zero, io2.neg}),
                    64'(prev_out));
            if (io2.out_valid && io2.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(io2.out_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 64'(io2.result), 64'(mon_e.res));
                    chk("flags_cout_ovf_zero_neg", 64'({io2.c_out, io2.ovf, io2.zero, io2.neg}), 64'(mon_e.fl));
                    if (mon_e.lat) chk("latency", 64'(cyc - mon_e.icyc), 64'(2));
                end
            end
            prev_stall = io2.out_valid && !io2.out_ready;
            prev_out   = {io2.out_valid, io2.result, io2.c_out, io2.ovf, io2.zero, io2.neg};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ic;
        int lat4;
        int lat8;
        int quiet;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 64'({io2.out_valid, io2.result, io2.c_out, io2.ovf, io2.zero, io2.neg}), 64'(0));
        chk("rst_out_valid_deep", 64'({io4.out_valid, io8.out_valid}), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(io2.in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed cases, consumer always ready so latency is exact
        send(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        send(2'b01, 32'h0000_0005, 32'h0000_0005, 1'b1);
        send(2'b01, 32'h0000_0000, 32'h0000_0001, 1'b1);
        send(2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        send(2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        send(2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        send(2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
        drain();

        // Random traffic with bubbles and random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(2'(($urandom_range(0, 3))), pick(), pick(), 1'b0);
        end
        drain();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with two transactions in flight: both must vanish
        send(2'b00, 32'h0000_0001, 32'h0000_0002, 1'b0);
        send(2'b01, 32'h0000_0009, 32'h0000_0004, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_midstream_out_valid", 64'(io2.out_valid), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (io2.out_valid) quiet++;
        end
        chk("post_rst_quiet", 64'(quiet), 64'(0));
        @(posedge clk);
        #1;
        send(2'b00, 32'h0000_FFFF, 32'h0000_0001, 1'b1);
        drain();

        // Carry across slice boundaries on the deeper pipelines
        cv = 1'b1;
        ca = 32'h0000_FFFF;
        @(negedge clk);
        chk("cc_in_ready", 64'({io4.in_ready, io8.in_ready}), 64'(2'b11));
        ic = cyc;
        @(posedge clk);
        #1;
        cv   = 1'b0;
        lat4 = -1;
        lat8 = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (io4.out_valid && lat4 < 0) begin
                lat4 = cyc - ic;
                chk("cc4_result", 64'(io4.result), 64'(32'h0001_0000));
                chk("cc4_flags", 64'({io4.c_out, io4.ovf, io4.zero, io4.neg}), 64'(0));
            end
            if (io8.out_valid && lat8 < 0) begin
                lat8 = cyc - ic;
                chk("cc8_result", 64'(io8.result), 64'(32'h0001_0000));
                chk("cc8_flags", 64'({io8.c_out, io8.ovf, io8.zero, io8.neg}), 64'(0));
            end
        end
        chk("cc4_latency", 64'(lat4), 64'(4));
        chk("cc8_latency", 64'(lat8), 64'(8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
